// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART transmitter among N_REQ requesters.
// Optional WAIT-state timeout abort is compiled in when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     ack,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_done,
    output logic                 busy,
    output logic [2:0]           owner,
    output logic                 err
);
    // state | meaning
    // IDLE  | no grant; pick round-robin winner when any req is set
    // START | tx_start pulse to the transmitter
    // WAIT  | waiting for a tx_done rising edge (or timeout abort)
    // ACK   | ack pulse to owner, advance round-robin pointer
    typedef enum logic [1:0] {IDLE, START, WAIT, ACK} state_t;

    state_t     state;
    logic [2:0] ptr;
    logic       done_q;
    logic       done_rise;
    logic       tmo_hit;
    logic       grant_valid;
    logic [2:0] grant_idx;
    logic [2:0] owner_next;

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("uart_tx_arbiter: illegal parameter value");
    end

    assign done_rise  = tx_done & ~done_q;
    assign owner_next = (owner == 3'(N_REQ - 1)) ? 3'd0 : owner + 3'd1;

    always_comb begin
        int idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = 3'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            ack      <= '0;
            busy     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q   <= tx_done;
            tx_start <= 1'b0;
            ack      <= '0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        state    <= START;
                        owner    <= grant_idx;
                        tx_data  <= req_data[8*int'(grant_idx) +: 8];
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                START: state <= WAIT;
                WAIT: begin
                    // a tx_done already high on entry leaves done_q set, so it never counts
                    if (done_rise) begin
                        state <= ACK;
                        ack   <= {{(N_REQ-1){1'b0}}, 1'b1} << owner;
                    end else if (tmo_hit) begin
                        state <= IDLE;
                        ptr   <= owner_next;
                        busy  <= 1'b0;
                    end
                end
                ACK: begin
                    state <= IDLE;
                    ptr   <= owner_next;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            err <= (state == WAIT) && !done_rise && tmo_hit;
            if (state == START)
                tmo_cnt <= '0;
            else if (state == WAIT)
                tmo_cnt <= tmo_cnt + TW'(1);
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (4 requesters, TIMEOUT_CYCLES=100).
module tb_uart_tx_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   ack;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_done = 1'b0;
    logic           busy;
    logic [2:0]     owner;
    logic           err;

    int n_checks = 0;
    int n_fail   = 0;
    int n_ack    = 0;
    int n_err    = 0;

    logic [7:0] bytes [N] = '{8'hA5, 8'h3C, 8'h5A, 8'hC3};

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
        .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
        .busy(busy), .owner(owner), .err(err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ack must be one-hot when active and never coincide with tx_start
    always @(negedge clk) begin
        if (ack != '0) n_ack++;
        if (err) n_err++;
        if (ack != '0 || tx_start)
            check("ack_onehot_excl", 32'($countones(ack)), tx_start ? 32'd0 : 32'd1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_start(input string tag, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!tx_start && lat < 300);
        check(tag, 32'(tx_start), 32'd1);
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        check({tag, "_ack"},      32'(ack),      32'd0);
        check({tag, "_busy"},     32'(busy),     32'd0);
        check({tag, "_owner"},    32'(owner),    32'd0);
        check({tag, "_tx_data"},  32'(tx_data),  32'd0);
        check({tag, "_err"},      32'(err),      32'd0);
    endtask

    initial begin
        int lat;
        int a0;
        int c;
        for (int i = 0; i < N; i++) req_data[8*i +: 8] = bytes[i];

        // reset
        cyc(3);
        check_idle_outputs("reset");
        rst = 1'b1;

        // single request, done 50 cycles after start
        cyc(1);
        req = 4'b0100;
        wait_start("t1_start", lat);
        check("t1_latency", 32'(lat), 32'd1);
        check("t1_tx_data", 32'(tx_data), 32'h5A);
        check("t1_owner",   32'(owner),   32'd2);
        check("t1_busy",    32'(busy),    32'd1);
        cyc(1);
        check("t1_start_pulse", 32'(tx_start), 32'd0);
        cyc(48);
        check("t1_no_early_ack", 32'(n_ack), 32'd0);
        pulse_done();
        check("t1_ack", 32'(ack), 32'b0100);
        req = '0;
        cyc(1);
        check("t1_ack_pulse", 32'(ack), 32'd0);
        check("t1_busy_end",  32'(busy), 32'd0);
        check("t1_ack_count", 32'(n_ack), 32'd1);

        // contention from ptr=0: order 0,1,2,3,0, back-to-back
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
        req = 4'b1111;
        a0 = n_ack;
        for (int i = 0; i < 5; i++) begin
            wait_start("t2_start", lat);
            check("t2_latency", 32'(lat), (i == 0) ? 32'd1 : 32'd2);
            check("t2_owner",   32'(owner),   32'(i % N));
            check("t2_tx_data", 32'(tx_data), 32'(bytes[i % N]));
            cyc(3);
            pulse_done();
            check("t2_ack", 32'(ack), 32'(1 << (i % N)));
        end
        req = '0;
        cyc(1);
        check("t2_ack_count", 32'(n_ack - a0), 32'd5);

        // stale tx_done held high from before the grant (ptr=1 -> winner 0)
        tx_done = 1'b1;
        cyc(2);
        req = 4'b0001;
        a0 = n_ack;
        wait_start("t3_start", lat);
        check("t3_owner", 32'(owner), 32'd0);
        cyc(10);
        check("t3_no_ack_stale", 32'(n_ack - a0), 32'd0);
        check("t3_busy_wait",    32'(busy), 32'd1);
        tx_done = 1'b0;
        cyc(1);
        tx_done = 1'b1;
        cyc(1);
        check("t3_ack", 32'(ack), 32'b0001);
        req = '0;
        tx_done = 1'b0;
        cyc(1);

        // requester drops req one cycle after tx_start
        req = 4'b0010;
        wait_start("t4_start", lat);
        check("t4_owner", 32'(owner), 32'd1);
        cyc(1);
        req = '0;
        cyc(5);
        pulse_done();
        check("t4_ack", 32'(ack), 32'b0010);
        cyc(1);

        // reset in WAIT abandons the byte; ptr returns to 0
        req = 4'b1000;
        wait_start("t5_start", lat);
        check("t5_owner", 32'(owner), 32'd3);
        a0 = n_ack;
        cyc(3);
        rst = 1'b0;
        cyc(1);
        check_idle_outputs("t5_reset");
        rst = 1'b1;
        req = '0;
        cyc(2);
        pulse_done();
        cyc(2);
        check("t5_no_ack", 32'(n_ack - a0), 32'd0);
        check("t5_idle",   32'(busy), 32'd0);
        req = 4'b1010;
        wait_start("t5_regrant", lat);
        check("t5_owner_ptr0", 32'(owner), 32'd1);
        // a done edge coinciding with START is ignored
        tx_done = 1'b1;
        cyc(1);
        tx_done = 1'b0;
        cyc(4);
        check("t5_start_edge_ignored", 32'(n_ack - a0), 32'd0);
        pulse_done();
        check("t5_ack", 32'(ack), 32'b0010);
        req = '0;
        cyc(1);

        // tx_done held low in WAIT (ptr=2 -> winner 2, then 0 pending)
        req = 4'b0101;
        wait_start("t6_start", lat);
        check("t6_owner", 32'(owner), 32'd2);
        a0 = n_ack;
`ifdef UART_ARB_TIMEOUT_EN
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!err && c < 200);
        check("t6_err_delay", 32'(c), 32'd101);
        check("t6_no_ack", 32'(n_ack - a0), 32'd0);
        check("t6_busy_abort", 32'(busy), 32'd0);
        cyc(1);
        check("t6_err_pulse", 32'(err), 32'd0);
        check("t6_next_start", 32'(tx_start), 32'd1);
        check("t6_next_owner", 32'(owner), 32'd0);
        cyc(2);
        pulse_done();
        check("t6_next_ack", 32'(ack), 32'b0001);
`else
        c = 0;
        cyc(110);
        check("t6_no_err", 32'(n_err), 32'd0);
        check("t6_still_busy", 32'(busy), 32'd1);
        check("t6_no_ack", 32'(n_ack - a0), 32'd0);
        pulse_done();
        check("t6_ack", 32'(ack), 32'b0100);
        wait_start("t6_next_start", lat);
        check("t6_next_owner", 32'(owner), 32'd0);
        cyc(2);
        pulse_done();
        check("t6_next_ack", 32'(ack), 32'b0001);
`endif
        req = '0;
        cyc(2);
`ifdef UART_ARB_TIMEOUT_EN
        check("total_err",  32'(n_err), 32'd1);
        check("total_acks", 32'(n_ack), 32'd10);
`else
        check("total_err",  32'(n_err), 32'd0);
        check("total_acks", 32'(n_ack), 32'd11);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters (legal range 2..8).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 20000, giving the clk cycles allowed in WAIT before abort (used only with UART_ARB_TIMEOUT_EN).
REQ-003 The block SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 The block SHALL have port req  input  N_REQ  per-requester send request, level, held until ack.
REQ-006 The block SHALL have port req_data  input  8*N_REQ  byte of requester i on bits [8i+7:8i], stable while req[i]=1.
REQ-007 The block SHALL have port ack  output  N_REQ  one-cycle pulse to the owner when its byte has been sent.
REQ-008 The block SHALL have port tx_start  output  1  one-cycle start pulse to the UART transmitter.
REQ-009 The block SHALL have port tx_data  output  8  byte presented to the transmitter, held from tx_start until ack.
REQ-010 The block SHALL have port tx_done  input  1  transmitter completion flag, synchronous to clk, may remain high for many cycles.
REQ-011 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 The block SHALL have port owner  output  3  index of the current or most recent grant.
REQ-013 The block SHALL have port err  output  1  one-cycle pulse on timeout abort.

Function
REQ-014 The FSM SHALL have states IDLE, START, WAIT, ACK.
REQ-015 In IDLE with req!=0, the next edge SHALL select the winner, load owner and tx_data from req_data of the winner, and enter START; with req==0 it SHALL stay in IDLE.
REQ-016 Selection SHALL be round-robin: scan indices ptr, ptr+1, ... mod N_REQ; the first set req bit wins.
REQ-017 START SHALL assert tx_start for exactly one cycle, then enter WAIT.
REQ-018 tx_done SHALL pass through a one-register edge detector; only a 0->1 transition counts as completion.
REQ-019 WAIT SHALL enter ACK on the first cycle a tx_done rising edge is detected; a tx_done already high on entry SHALL NOT count.
REQ-020 tx_done edges outside WAIT SHALL be ignored.
REQ-021 ACK SHALL pulse ack[owner] for one cycle, set ptr to (owner+1) mod N_REQ, and return to IDLE.
REQ-022 Minimum service time SHALL be 1 (IDLE) + 1 (START) + WAIT + 1 (ACK) cycles; back-to-back grants SHALL be possible with no extra idle cycle beyond IDLE.
REQ-023 Deassertion of req[owner] after grant SHALL NOT abort the transfer; ack SHALL still pulse.
REQ-024 New or changed req bits during START/WAIT/ACK SHALL NOT affect the current grant.
REQ-025 At most one ack bit SHALL be high in any cycle; tx_start and ack SHALL never be high together.

Reset
REQ-026 With rst=0 at a clock edge: state=IDLE, ptr=0, owner=0, tx_data=0, tx_start=0, ack=0, busy=0, err=0, edge register=0, timeout counter=0.
REQ-027 Reset mid-transfer SHALL abandon the byte with no ack and no err.

Configuration
REQ-028 Macro UART_ARB_TIMEOUT_EN defined: a counter SHALL clear on entering WAIT and increment each WAIT cycle; reaching TIMEOUT_CYCLES without a tx_done edge SHALL pulse err for one cycle, give no ack, set ptr to (owner+1) mod N_REQ, and return to IDLE.
REQ-029 Macro UART_ARB_TIMEOUT_EN undefined: no counter SHALL exist, err SHALL be constant 0, and WAIT SHALL last until a tx_done edge.

Verification
REQ-030 Single request: req=4'b0100, byte 0x5A, tx_done rises 50 cycles after tx_start -> tx_start one pulse, tx_data=0x5A, owner=2, ack=4'b0100 one pulse.
REQ-031 Contention: req=4'b1111 held, tx_done pulses after each start -> grant order 0,1,2,3,0, one ack per grant.
REQ-032 Stale done: tx_done held high from before the grant -> no ack until tx_done falls and rises again.
REQ-033 Drop request: req[1] deasserted one cycle after tx_start -> transfer completes, ack[1] still pulses.
REQ-034 Reset mid-WAIT: rst=0 for one cycle -> all outputs 0, ptr=0, no ack; next req=4'b0010 granted normally.
REQ-035 With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=100, tx_done held low -> err pulses after 100 WAIT cycles, no ack, next pending requester served.
